// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-control bundle between the 5-stage datapath and hazard_ctrl_unit.
// master = datapath side (drives pipeline status, receives latch controls),
// slave  = hazard unit side.
interface hazard_ctrl_unit_if #(
    parameter int REGADDR_W = 5,
    parameter int CNT_W     = 16
);
    logic [REGADDR_W-1:0] ifid_rs;
    logic [REGADDR_W-1:0] ifid_rt;
    logic [REGADDR_W-1:0] idex_rs;
    logic [REGADDR_W-1:0] idex_rt;
    logic [REGADDR_W-1:0] idex_rd;
    logic                 idex_memread;
    logic [REGADDR_W-1:0] exmem_rd;
    logic [REGADDR_W-1:0] memwb_rd;
    logic                 exmem_regwrite;
    logic                 memwb_regwrite;
    logic                 ihit;
    logic                 dhit;
    logic                 dmemREN;
    logic                 dmemWEN;
    logic                 branch_taken;
    logic                 jump;
    logic                 halt;
    logic                 stall_ifid;
    logic                 stall_idex;
    logic                 stall_xmem;
    logic                 stall_wb;
    logic                 flush_ifid;
    logic                 flush_idex;
    logic                 flush_xmem;
    logic                 flush_wb;
    logic                 pc_en;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;
    logic                 dmem_timeout;

    modport master (
        output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, idex_memread,
               exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
               ihit, dhit, dmemREN, dmemWEN, branch_taken, jump, halt,
        input  stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb,
               pc_en, fwd_a, fwd_b, stall_cnt, flush_cnt, dmem_timeout
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, idex_memread,
               exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
               ihit, dhit, dmemREN, dmemWEN, branch_taken, jump, halt,
        output stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb,
               pc_en, fwd_a, fwd_b, stall_cnt, flush_cnt, dmem_timeout
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Latch controls are decided in the same cycle as the hazard they answer
// (the datapath latches need them before the next edge); the FSM, bubble
// count, dmem wait timer, watchdog flag and perf counters are registered.
// The reset cycle and the cycle right after it are both "blank": every
// control is low and all registered state is held at its reset value.
module hazard_ctrl_unit #(
    parameter int REGADDR_W        = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int BR_RESOLVE_STAGE = 1,
    parameter int CNT_W            = 16,
    parameter int DMEM_TIMEOUT     = 255
) (
    input logic          CLK,
    input logic          RST,
    hazard_ctrl_unit_if.slave hz
);
    localparam int TMR_W = $clog2(DMEM_TIMEOUT + 1);
    localparam int BUB_W = 3;
    localparam logic [TMR_W-1:0]     TMR_MAX    = TMR_W'(DMEM_TIMEOUT);
    localparam logic [BUB_W-1:0]     BUB_RELOAD = BUB_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [REGADDR_W-1:0] REG_ZERO   = {REGADDR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_LOAD_USE  = 2'b01,
        ST_DMEM_WAIT = 2'b10,
        ST_HALTED    = 2'b11
    } state_t;

    state_t             state_r,   st_nxt_s;
    logic [BUB_W-1:0]   bub_r,     bub_nxt_s;
    logic [TMR_W-1:0]   tmr_r,     tmr_nxt_s;
    logic               tmo_r,     tmo_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               rst_d_r;
    logic               blank_s;
    logic               dmem_miss_s;
    logic               ctrl_xfer_s;
    logic               load_use_s;
    logic               stall_inc_s;
    logic               flush_inc_s;
    logic               st_ifid_s, st_idex_s, st_xmem_s, st_wb_s;
    logic               fl_ifid_s, fl_idex_s, fl_xmem_s, fl_wb_s;
    logic               pc_en_s;
    logic [1:0]         fwd_a_s, fwd_b_s;

    // Forwarding select for one EX operand; EX/MEM is the younger result so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [REGADDR_W-1:0] src,
        input logic [REGADDR_W-1:0] ex_rd,
        input logic                 ex_wr,
        input logic [REGADDR_W-1:0] mem_rd,
        input logic                 mem_wr
    );
        logic [1:0] sel;
        if (ex_wr && (ex_rd != REG_ZERO) && (ex_rd == src)) begin
            sel = 2'b10;
        end else if (mem_wr && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign blank_s     = RST | rst_d_r;
    assign dmem_miss_s = (hz.dmemREN | hz.dmemWEN) & ~hz.dhit;
    assign ctrl_xfer_s = hz.branch_taken | hz.jump;
    assign load_use_s  = hz.idex_memread && (hz.idex_rd != REG_ZERO) &&
                         ((hz.idex_rd == hz.ifid_rs) || (hz.idex_rd == hz.ifid_rt));

    // Remember that reset was high last cycle so the following cycle stays blank too.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rst_d_r <= 1'b1;
        end else begin
            rst_d_r <= 1'b0;
        end
    end

    // Operand forwarding selects, forced to regfile while blank.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (blank_s) begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end else begin
            fwd_a_s = fwd_sel(hz.idex_rs, hz.exmem_rd, hz.exmem_regwrite,
                              hz.memwb_rd, hz.memwb_regwrite);
            fwd_b_s = fwd_sel(hz.idex_rt, hz.exmem_rd, hz.exmem_regwrite,
                              hz.memwb_rd, hz.memwb_regwrite);
        end
    end

    // Prioritised hazard resolution: halt > dmem miss > control transfer > load-use > imiss.
    always_comb begin
        st_nxt_s    = state_r;
        bub_nxt_s   = bub_r;
        tmr_nxt_s   = tmr_r;
        tmo_nxt_s   = tmo_r;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        st_ifid_s   = 1'b0;
        st_idex_s   = 1'b0;
        st_xmem_s   = 1'b0;
        st_wb_s     = 1'b0;
        fl_ifid_s   = 1'b0;
        fl_idex_s   = 1'b0;
        fl_xmem_s   = 1'b0;
        fl_wb_s     = 1'b0;
        pc_en_s     = 1'b0;
        if (blank_s) begin
            st_nxt_s  = ST_RUN;
            bub_nxt_s = {BUB_W{1'b0}};
            tmr_nxt_s = {TMR_W{1'b0}};
            tmo_nxt_s = 1'b0;
        end else if ((state_r == ST_HALTED) || hz.halt) begin
            // Freeze the whole pipe; only reset releases it.
            st_ifid_s = 1'b1;
            st_idex_s = 1'b1;
            st_xmem_s = 1'b1;
            st_wb_s   = 1'b1;
            st_nxt_s  = ST_HALTED;
        end else if (dmem_miss_s) begin
            // Hold everything up to MEM and drain a bubble into WB while waiting.
            st_ifid_s   = 1'b1;
            st_idex_s   = 1'b1;
            st_xmem_s   = 1'b1;
            fl_wb_s     = 1'b1;
            stall_inc_s = 1'b1;
            st_nxt_s    = ST_DMEM_WAIT;
            bub_nxt_s   = {BUB_W{1'b0}};
            if (tmr_r == TMR_MAX) begin
                tmr_nxt_s = tmr_r;
            end else begin
                tmr_nxt_s = tmr_r + TMR_W'(1);
            end
            tmo_nxt_s = tmo_r | (tmr_nxt_s == TMR_MAX);
        end else begin
            tmr_nxt_s = {TMR_W{1'b0}};
            st_nxt_s  = ST_RUN;
            bub_nxt_s = {BUB_W{1'b0}};
            if (ctrl_xfer_s) begin
                // Kill the wrong-path instructions younger than the resolve stage.
                fl_ifid_s   = 1'b1;
                fl_idex_s   = (BR_RESOLVE_STAGE == 2);
                pc_en_s     = 1'b1;
                flush_inc_s = 1'b1;
            end else if (state_r == ST_LOAD_USE) begin
                st_ifid_s   = 1'b1;
                fl_idex_s   = 1'b1;
                stall_inc_s = 1'b1;
                bub_nxt_s   = bub_r - BUB_W'(1);
                if (bub_r > BUB_W'(1)) begin
                    st_nxt_s = ST_LOAD_USE;
                end else begin
                    st_nxt_s = ST_RUN;
                end
            end else if (load_use_s) begin
                st_ifid_s   = 1'b1;
                fl_idex_s   = 1'b1;
                stall_inc_s = 1'b1;
                if (LOAD_USE_BUBBLES > 1) begin
                    st_nxt_s  = ST_LOAD_USE;
                    bub_nxt_s = BUB_RELOAD;
                end else begin
                    st_nxt_s  = ST_RUN;
                    bub_nxt_s = {BUB_W{1'b0}};
                end
            end else if (!hz.ihit) begin
                fl_ifid_s   = 1'b1;
                stall_inc_s = 1'b1;
            end else begin
                pc_en_s = 1'b1;
            end
        end
    end

    // FSM, bubble count, wait timer, watchdog flag and saturating perf counters.
    always_ff @(posedge CLK) begin
        if (blank_s) begin
            state_r     <= ST_RUN;
            bub_r       <= {BUB_W{1'b0}};
            tmr_r       <= {TMR_W{1'b0}};
            tmo_r       <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= st_nxt_s;
            bub_r   <= bub_nxt_s;
            tmr_r   <= tmr_nxt_s;
            tmo_r   <= tmo_nxt_s;
            if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign hz.stall_ifid   = st_ifid_s;
    assign hz.stall_idex   = st_idex_s;
    assign hz.stall_xmem   = st_xmem_s;
    assign hz.stall_wb     = st_wb_s;
    assign hz.flush_ifid   = fl_ifid_s;
    assign hz.flush_idex   = fl_idex_s;
    assign hz.flush_xmem   = fl_xmem_s;
    assign hz.flush_wb     = fl_wb_s;
    assign hz.pc_en        = pc_en_s;
    assign hz.fwd_a        = fwd_a_s;
    assign hz.fwd_b        = fwd_b_s;
    assign hz.stall_cnt    = stall_cnt_r;
    assign hz.flush_cnt    = flush_cnt_r;
    assign hz.dmem_timeout = tmo_r;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two differently parameterised instances share
// one stimulus stream (directed steps, then random cycles) and are checked
// every cycle against a rule-level reference model.
module tb_hazard_ctrl_unit;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
    logic       idex_memread, exmem_regwrite, memwb_regwrite;
    logic       ihit, dhit, dmemREN, dmemWEN, branch_taken, jump, halt;

    hazard_ctrl_unit_if #(.REGADDR_W(5), .CNT_W(16)) hza ();
    hazard_ctrl_unit_if #(.REGADDR_W(5), .CNT_W(4))  hzb ();

    assign hza.ifid_rs = ifid_rs;   assign hzb.ifid_rs = ifid_rs;
    assign hza.ifid_rt = ifid_rt;   assign hzb.ifid_rt = ifid_rt;
    assign hza.idex_rs = idex_rs;   assign hzb.idex_rs = idex_rs;
    assign hza.idex_rt = idex_rt;   assign hzb.idex_rt = idex_rt;
    assign hza.idex_rd = idex_rd;   assign hzb.idex_rd = idex_rd;
    assign hza.idex_memread = idex_memread;     assign hzb.idex_memread = idex_memread;
    assign hza.exmem_rd = exmem_rd;             assign hzb.exmem_rd = exmem_rd;
    assign hza.memwb_rd = memwb_rd;             assign hzb.memwb_rd = memwb_rd;
    assign hza.exmem_regwrite = exmem_regwrite; assign hzb.exmem_regwrite = exmem_regwrite;
    assign hza.memwb_regwrite = memwb_regwrite; assign hzb.memwb_regwrite = memwb_regwrite;
    assign hza.ihit = ihit;         assign hzb.ihit = ihit;
    assign hza.dhit = dhit;         assign hzb.dhit = dhit;
    assign hza.dmemREN = dmemREN;   assign hzb.dmemREN = dmemREN;
    assign hza.dmemWEN = dmemWEN;   assign hzb.dmemWEN = dmemWEN;
    assign hza.branch_taken = branch_taken;     assign hzb.branch_taken = branch_taken;
    assign hza.jump = jump;         assign hzb.jump = jump;
    assign hza.halt = halt;         assign hzb.halt = halt;

    hazard_ctrl_unit #(.REGADDR_W(5), .LOAD_USE_BUBBLES(3), .BR_RESOLVE_STAGE(2),
                       .CNT_W(16), .DMEM_TIMEOUT(8))
        u_dut_a (.CLK(CLK), .RST(RST), .hz(hza));
    hazard_ctrl_unit #(.REGADDR_W(5), .LOAD_USE_BUBBLES(1), .BR_RESOLVE_STAGE(1),
                       .CNT_W(4), .DMEM_TIMEOUT(3))
        u_dut_b (.CLK(CLK), .RST(RST), .hz(hzb));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, one slot per instance.
    bit m_prst [2];
    bit m_halt [2];
    int m_lu   [2];
    int m_wait [2];
    bit m_to   [2];
    int m_sc   [2];
    int m_fc   [2];

    function automatic int p_bub(input int i);   return (i == 0) ? 3 : 1;      endfunction
    function automatic int p_stage(input int i); return (i == 0) ? 2 : 1;      endfunction
    function automatic int p_lim(input int i);   return (i == 0) ? 8 : 3;      endfunction
    function automatic int p_cmax(input int i);  return (i == 0) ? 65535 : 15; endfunction

    function automatic bit lu_cond();
        return idex_memread && (idex_rd != 5'd0) && ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    endfunction

    // Which rule governs this cycle: 0 blank, 1 halt, 2 dmem miss, 3 branch, 4 load-use, 5 imiss, 6 run.
    function automatic int cond_of(input int i);
        if (RST || m_prst[i])                return 0;
        if (m_halt[i] || halt)               return 1;
        if ((dmemREN || dmemWEN) && !dhit)   return 2;
        if (branch_taken || jump)            return 3;
        if ((m_lu[i] > 0) || lu_cond())      return 4;
        if (!ihit)                           return 5;
        return 6;
    endfunction

    // {stall ifid,idex,xmem,wb, flush ifid,idex,xmem,wb, pc_en}
    function automatic logic [8:0] exp_ctl(input int i);
        logic [8:0] v;
        case (cond_of(i))
            1:       v = 9'b1111_0000_0;
            2:       v = 9'b1110_0001_0;
            3:       v = {4'b0000, 1'b1, (p_stage(i) == 2), 2'b00, 1'b1};
            4:       v = 9'b1000_0100_0;
            5:       v = 9'b0000_1000_0;
            6:       v = 9'b0000_0000_1;
            default: v = 9'b0000_0000_0;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] exp_fwd1(input logic [4:0] src);
        if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == src) return 2'b10;
        if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] exp_fwd(input int i);
        if (cond_of(i) == 0) return 4'b0000;
        return {exp_fwd1(idex_rs), exp_fwd1(idex_rt)};
    endfunction

    // Advance the model across one rising edge.
    task automatic upd(input int i);
        int c;
        logic [8:0] e;
        c = cond_of(i);
        e = exp_ctl(i);
        if (RST) begin
            m_prst[i] = 1'b1; m_halt[i] = 1'b0; m_lu[i] = 0; m_wait[i] = 0;
            m_to[i] = 1'b0; m_sc[i] = 0; m_fc[i] = 0;
        end else if (m_prst[i]) begin
            m_prst[i] = 1'b0;
        end else begin
            if (!e[0] && c != 1 && m_sc[i] < p_cmax(i)) m_sc[i]++;
            if (c == 3 && m_fc[i] < p_cmax(i)) m_fc[i]++;
            if (c == 1) begin
                m_halt[i] = 1'b1;
            end else if (c == 2) begin
                if (m_wait[i] < p_lim(i)) m_wait[i]++;
                if (m_wait[i] >= p_lim(i)) m_to[i] = 1'b1;
                m_lu[i] = 0;
            end else begin
                m_wait[i] = 0;
                if (c == 3) m_lu[i] = 0;
                else if (c == 4) m_lu[i] = (m_lu[i] > 0) ? m_lu[i] - 1 : p_bub(i) - 1;
            end
        end
    endtask

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h t=%0t", tag, i, obs, exp, $time);
        end
    endtask

    task automatic check_inst(input int i);
        logic [8:0] ctl;
        logic [3:0] fw;
        logic [31:0] sc, fc;
        logic to;
        if (i == 0) begin
            ctl = {hza.stall_ifid, hza.stall_idex, hza.stall_xmem, hza.stall_wb,
                   hza.flush_ifid, hza.flush_idex, hza.flush_xmem, hza.flush_wb, hza.pc_en};
            fw = {hza.fwd_a, hza.fwd_b};
            sc = 32'(hza.stall_cnt); fc = 32'(hza.flush_cnt); to = hza.dmem_timeout;
        end else begin
            ctl = {hzb.stall_ifid, hzb.stall_idex, hzb.stall_xmem, hzb.stall_wb,
                   hzb.flush_ifid, hzb.flush_idex, hzb.flush_xmem, hzb.flush_wb, hzb.pc_en};
            fw = {hzb.fwd_a, hzb.fwd_b};
            sc = 32'(hzb.stall_cnt); fc = 32'(hzb.flush_cnt); to = hzb.dmem_timeout;
        end
        check("ctl",       i, 32'(ctl), 32'(exp_ctl(i)));
        check("fwd",       i, 32'(fw),  32'(exp_fwd(i)));
        check("stall_cnt", i, sc,       32'(m_sc[i]));
        check("flush_cnt", i, fc,       32'(m_fc[i]));
        check("timeout",   i, 32'(to),  32'(m_to[i]));
    endtask

    // One clock: sample mid-low-phase, then step the model over the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            check_inst(0);
            check_inst(1);
            @(posedge CLK);
            upd(0);
            upd(1);
            @(negedge CLK);
        end
    endtask

    task automatic idle();
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0; idex_rd = 5'd0;
        exmem_rd = 5'd0; memwb_rd = 5'd0; idex_memread = 1'b0;
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0; ihit = 1'b1; dhit = 1'b1;
        dmemREN = 1'b0; dmemWEN = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        @(negedge CLK);
        step(2);
        RST = 1'b0;
        step(1);                               // post-reset blank cycle
        // Forwarding priority and $0 exclusion
        exmem_rd = 5'd5; exmem_regwrite = 1'b1; memwb_rd = 5'd5; memwb_regwrite = 1'b1;
        idex_rs = 5'd5;
        step(1);
        exmem_rd = 5'd0;
        step(1);
        idle(); idex_rt = 5'd0;
        step(1);
        // Load-use: lw to $8 in EX, consumer in ID
        idex_memread = 1'b1; idex_rd = 5'd8; ifid_rs = 5'd8;
        step(1);
        idle();
        step(4);
        // Single-cycle taken branch
        branch_taken = 1'b1;
        step(1);
        idle();
        step(1);
        // Dmem miss for 10 cycles with a branch pending behind it
        dmemREN = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
        step(10);
        dhit = 1'b1;
        step(1);
        idle();
        step(2);
        // Reset in the middle of a load-use bubble train
        idex_memread = 1'b1; idex_rd = 5'd8; ifid_rt = 5'd8;
        step(1);
        idle();
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        step(3);
        // Halt is sticky until reset
        halt = 1'b1;
        step(1);
        halt = 1'b0; ihit = 1'b0; branch_taken = 1'b1;
        step(4);
        idle();
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        step(2);
        // Randomised traffic
        for (int r = 0; r < 600; r++) begin
            RST            = ($urandom_range(0, 59) == 0);
            halt           = ($urandom_range(0, 149) == 0);
            ifid_rs        = 5'($urandom_range(0, 3));
            ifid_rt        = 5'($urandom_range(0, 3));
            idex_rs        = 5'($urandom_range(0, 3));
            idex_rt        = 5'($urandom_range(0, 3));
            idex_rd        = 5'($urandom_range(0, 3));
            exmem_rd       = 5'($urandom_range(0, 3));
            memwb_rd       = 5'($urandom_range(0, 3));
            idex_memread   = ($urandom_range(0, 2) == 0);
            exmem_regwrite = ($urandom_range(0, 1) == 0);
            memwb_regwrite = ($urandom_range(0, 1) == 0);
            ihit           = ($urandom_range(0, 4) != 0);
            dhit           = ($urandom_range(0, 2) != 0);
            dmemREN        = ($urandom_range(0, 3) == 0);
            dmemWEN        = ($urandom_range(0, 5) == 0);
            branch_taken   = ($urandom_range(0, 5) == 0);
            jump           = ($urandom_range(0, 9) == 0);
            step(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
